bus_arb_mux: RTL
================

# bus_arb_mux

Parametrised, registered successor to the datapath bus multiplexer. Selects one of N WIDTH-bit sources onto the shared datapath bus from per-source out-enables, using either fixed priority or round-robin arbitration. Registers the selected word for one cycle, holds the last driven value when the bus is idle, and flags cycles where more than one source is enabled. Sits between register file/special registers (HI, LO, Z, PC, MDR, ports) and all bus consumers.

## Interface
- WIDTH, 32, data width of every source and of the bus
- N, 32, number of sources (2..64); index 0 is highest fixed priority
- RR, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

- clk  input  1  rising-edge clock
- clr  input  1  reset; asynchronous, active-high
- src_data  input  N*WIDTH  flattened sources; source i at [i*WIDTH +: WIDTH]
- src_out  input  N  per-source out-enable (request)
- hold  input  1  freeze bus_out, grant and bus_valid; rr_ptr does not advance
- bus_out  output  WIDTH  registered bus value
- bus_valid  output  1  bus_out was loaded from a source in the previous cycle
- grant  output  N  registered one-hot index of the source driving bus_out; 0 when idle
- conflict  output  1  sticky: set when more than one src_out bit is high on a non-hold cycle
- conflict_cnt  output  8  saturating count of conflict cycles
- conflict_ack  input  1  synchronous clear of conflict and conflict_cnt

## Operation
- Each non-hold cycle: winner w chosen combinationally from src_out.
  - RR=0: lowest set index.
  - RR=1: first set index at or above rr_ptr, wrapping from N-1 to 0.
- Winner exists: bus_out <= src_data[w], grant <= one-hot(w), bus_valid <= 1; RR=1: rr_ptr <= (w+1) mod N.
- No bit set: bus_out holds previous value (bus keeper), grant <= 0, bus_valid <= 0, rr_ptr unchanged.
- hold=1: all registers except conflict logic keep value; src_out ignored; conflicts not counted.
- Conflict: popcount(src_out) >= 2 and hold=0 → conflict <= 1, conflict_cnt <= min(cnt+1, 255). Winner is still driven normally.
- conflict_ack=1: conflict <= 0, conflict_cnt <= 0. If a conflict occurs in the same cycle, ack wins, and that cycle is not counted.
- Reset values: bus_out 0, bus_valid 0, grant 0, conflict 0, conflict_cnt 0, rr_ptr 0.

## Timing
- Latency: src_out/src_data sampled at edge k appear on bus_out/grant/bus_valid after edge k (one cycle).
- No combinational path from inputs to any output.
- src_data changes while src_out is held are tracked each cycle (bus_out re-samples the same winner).
- clr asserted mid-transfer: outputs go to reset values immediately, without waiting for clk. First load occurs on the first edge after clr deasserts.
- Round-robin fairness: with all N requests held high, each source is granted exactly once every N cycles, starting from index 0 after reset.
- rr_ptr wrap: grant of N-1 sets rr_ptr to 0.

## Configuration
- BUS_CONFLICT_CHECK_EN defined: popcount detection, conflict and conflict_cnt are built as described.
- BUS_CONFLICT_CHECK_EN not defined: detection logic is removed. conflict and conflict_cnt are tied to 0 and conflict_ack is ignored. Arbitration is unchanged.

## Test plan
- Reset/idle: WIDTH=32, N=32, RR=0. Assert clr mid-cycle with bus_out=0xDEADBEEF → outputs 0 immediately. Release, src_out=0 → bus_valid=0, bus_out=0.
- Fixed priority: src_out bits 3 and 20 set, src[3]=0x11111111, src[20]=0x22222222 → next cycle bus_out=0x11111111, grant=1<<3, conflict=1, conflict_cnt=1.
- Bus keeper: load src 5=0xA5A5A5A5, then src_out=0 for 3 cycles → bus_out stays 0xA5A5A5A5, bus_valid=0, grant=0.
- Round-robin: RR=1, N=4, src_out=4'b1111 for 6 cycles → grant sequence 0,1,2,3,0,1. hold=1 for 2 cycles → grant stays 1. Release → grant=2.
- Saturation/ack: 300 consecutive 2-source cycles → conflict_cnt=255. conflict_ack coincident with another conflict → cnt=0, conflict=0 next cycle.
- Macro off: same stimulus as the fixed-priority scenario, built without BUS_CONFLICT_CHECK_EN → bus_out=0x11111111, conflict=0, conflict_cnt=0.

Source files
------------

// File: rtl/bus_arb_mux.sv
// Purpose : arbitrates N WIDTH-bit sources onto the shared datapath bus (fixed priority or round-robin), with bus keeper.
// Latency : one cycle from src_out/src_data to bus_out/grant/bus_valid; no combinational input-to-output path.
// Backpressure: hold freezes bus_out, grant, bus_valid and the round-robin pointer; requests are ignored while held.
// Build option: define BUS_CONFLICT_CHECK_EN to build multi-driver detection (conflict, conflict_cnt); otherwise both read 0.
module bus_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 32,
    parameter int RR    = 0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [N*WIDTH-1:0] src_data,
    input  logic [N-1:0]       src_out,
    input  logic               hold,
    output logic [WIDTH-1:0]   bus_out,
    output logic               bus_valid,
    output logic [N-1:0]       grant,
    output logic               conflict,
    output logic [7:0]         conflict_cnt,
    input  logic               conflict_ack
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

    // Unpacked view of the flattened source bus, so the winner index selects a word directly.
    logic [WIDTH-1:0] srcWord [N];

    for (genvar i = 0; i < N; i++) begin : gUnpack
        assign srcWord[i] = src_data[i*WIDTH +: WIDTH];
    end

    // Round-robin search start point; stays 0 in fixed-priority builds.
    logic [PTR_W-1:0] rrPtr;

    // Winner search results.
    logic             loFound;
    logic [PTR_W-1:0] loIdx;
    logic             hiFound;
    logic [PTR_W-1:0] hiIdx;
    logic             winFound;
    logic [PTR_W-1:0] winIdx;
    logic [PTR_W-1:0] nextPtr;
    logic [WIDTH-1:0] winData;
    logic [N-1:0]     winOneHot;

    // Find the lowest requester overall and, for round-robin, the lowest requester at or above
    // rrPtr. The scan runs downward so the last hit is the lowest index. Round-robin prefers the
    // upper search; if nothing is at or above the pointer the search wraps to the lowest requester.
    always_comb begin
        loFound = 1'b0;
        loIdx   = '0;
        hiFound = 1'b0;
        hiIdx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (src_out[i]) begin
                loFound = 1'b1;
                loIdx   = PTR_W'(i);
                if ((RR != 0) && (i >= int'(rrPtr))) begin
                    hiFound = 1'b1;
                    hiIdx   = PTR_W'(i);
                end
            end
        end
        winFound = loFound;
        winIdx   = hiFound ? hiIdx : loIdx;
    end

    // Winner data, one-hot grant and the pointer value that follows this winner (N-1 wraps to 0).
    always_comb begin
        winData   = srcWord[winIdx];
        winOneHot = N'(1) << winIdx;
        nextPtr   = (winIdx == LAST_IDX) ? '0 : winIdx + PTR_W'(1);
    end

    // Bus register: load the winner, or keep the last driven value when nobody requests.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus_out   <= '0;
            grant     <= '0;
            bus_valid <= 1'b0;
        end else if (!hold) begin
            if (winFound) begin
                bus_out   <= winData;
                grant     <= winOneHot;
                bus_valid <= 1'b1;
            end else begin
                grant     <= '0;
                bus_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer moves just past each granted source; idle and hold cycles leave it alone.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rrPtr <= '0;
        end else if ((RR != 0) && !hold && winFound) begin
            rrPtr <= nextPtr;
        end
    end

`ifdef BUS_CONFLICT_CHECK_EN
    // Two or more enables: clearing the lowest set bit still leaves something set.
    logic multiReq;
    assign multiReq = |(src_out & (src_out - N'(1)));

    // Sticky conflict flag and saturating counter; an acknowledge wins over a same-cycle conflict.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            conflict     <= 1'b0;
            conflict_cnt <= 8'd0;
        end else if (conflict_ack) begin
            conflict     <= 1'b0;
            conflict_cnt <= 8'd0;
        end else if (!hold && multiReq) begin
            conflict <= 1'b1;
            if (conflict_cnt != 8'hFF) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end
`else
    // Detection not built: flags read as zero and the acknowledge has nothing to clear.
    logic unusedAck;
    assign unusedAck    = conflict_ack;
    assign conflict     = 1'b0;
    assign conflict_cnt = 8'd0;
`endif

endmodule
